latency_timer: RTL

- Parametrised, programmable cycle timer for cache/memory access latency modelling, e.g. the miss penalty wait or the write-back delay.
- A one-cycle start pulse launches a run of a programmable number of cycles; done flags the final cycle.
- Also supports periodic (auto-restart) mode, stall hold, abort, back-to-back restart, and detection of a start issued while already busy.

---
 rtl/latency_timer.sv | 104 ++++++++++
 1 files changed

// File: rtl/latency_timer.sv
// Programmable cycle timer for modelling cache/memory access latency.
// A start pulse launches a run of lim_reg cycles; done marks the final cycle.
module latency_timer #(
    parameter int WIDTH         = 4,
    parameter int DEFAULT_LIMIT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] limit,
    input  logic             periodic,
    input  logic             hold,
    input  logic             abort,
    output logic [WIDTH-1:0] out_val,
    output logic             busy,
    output logic             done,
    output logic             overrun
);

    localparam logic [WIDTH-1:0] DEF_LIM = WIDTH'(DEFAULT_LIMIT);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    typedef enum logic {IDLE, COUNT} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] lim_reg, lim_next;
    logic             per_reg, per_next;
    logic             overrun_reg, overrun_next;

    logic [WIDTH-1:0] start_lim;
    logic             terminal;

    assign start_lim = (limit == '0) ? DEF_LIM : limit;
    assign terminal  = (state_reg == COUNT) && (cnt_reg == lim_reg);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            lim_reg     <= DEF_LIM;
            per_reg     <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            lim_reg     <= lim_next;
            per_reg     <= per_next;
            overrun_reg <= overrun_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        lim_next     = lim_reg;
        per_next     = per_reg;
        overrun_next = 1'b0;
        case (state_reg)
            IDLE: begin
                // abort outranks a simultaneous start even when idle
                if (start && !abort) begin
                    lim_next   = start_lim;
                    per_next   = periodic;
                    cnt_next   = ONE;
                    state_next = COUNT;
                end
            end
            COUNT: begin
                if (abort) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else if (terminal) begin
                    // hold is deliberately ignored here so done is a single pulse
                    if (start) begin
                        lim_next = start_lim;
                        per_next = periodic;
                        cnt_next = ONE;
                    end else if (per_reg) begin
                        cnt_next = ONE;
                    end else begin
                        cnt_next   = '0;
                        state_next = IDLE;
                    end
                end else begin
                    overrun_next = start;
                    if (!hold) begin
                        cnt_next = cnt_reg + ONE;
                    end
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    assign out_val = cnt_reg;
    assign busy    = (state_reg == COUNT);
    assign done    = terminal;
    assign overrun = overrun_reg;

endmodule
